// File: rtl/prog_loader_pkg.sv
// Shared types and default sizing for the program loader and its instruction memory.
package prog_loader_pkg;

  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned HCYCL      = 5;
  localparam int unsigned STROB      = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

endpackage

// File: rtl/prog_mem.sv
// Instruction memory: register array, synchronous write, asynchronous read, async clear.
module prog_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader.sv
// Program loader and run sequencer: streams a program into instruction memory while
// holding the CPU in reset, then releases it and serves instructions from pc.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              load_req,
  input  logic              run_req,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] inst,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic [7:0]        checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        checksum_q, checksum_d;
  logic              done_q, done_d;
  logic              we;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    checksum_d = checksum_q;
    done_d     = 1'b0;
    we         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          state_d    = ST_LOAD;
          addr_d     = '0;
          checksum_d = '0;
        end else if (run_req) begin
          state_d = ST_RELEASE;
        end
      end
      ST_LOAD: begin
        if (wr_valid) begin
          we         = 1'b1;
          addr_d     = addr_q + 1'b1;
          checksum_d = checksum_q + 8'(wr_data);
          if (addr_q == LAST_ADDR) begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        // RELEASE always lasts one cycle, so done is simply its registered echo.
        state_d = ST_RUN;
        done_d  = 1'b1;
      end
      ST_RUN: begin
        if (load_req) begin
          state_d    = ST_LOAD;
          addr_d     = '0;
          checksum_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      checksum_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      checksum_q <= checksum_d;
      done_q     <= done_d;
    end
  end

  prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk_cpu),
    .rst   (reset),
    .we    (we),
    .waddr (addr_q),
    .wdata (wr_data),
    .raddr (pc),
    .rdata (rdata)
  );

  assign wr_ready  = (state_q == ST_LOAD);
  assign cpu_reset = (state_q != ST_RUN);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_RELEASE);
  assign done      = done_q;
  assign checksum  = checksum_q;
  assign inst      = (state_q == ST_RUN) ? rdata : '0;

endmodule
